// File: rtl/sram_mon_pkg.sv
// Shared types and widths for the SRAM bus monitor: log entry layout, checker status and byte-mask helper.
package sram_mon_pkg;

  localparam int unsigned MON_NUM_CH = 2;
  localparam int unsigned MON_ADDR_W = 20;
  localparam int unsigned MON_DATA_W = 32;
  localparam int unsigned MON_BE_W   = MON_DATA_W / 8;
  localparam int unsigned MON_CH_W   = (MON_NUM_CH > 1) ? $clog2(MON_NUM_CH) : 1;
  localparam int unsigned MON_OVF_W  = 16;

  typedef enum logic [1:0] {
    ARMED   = 2'd0,
    PASS    = 2'd1,
    FAIL    = 2'd2,
    TIMEOUT = 2'd3
  } mon_status_e;

  typedef struct packed {
    logic [MON_CH_W-1:0]   ch;
    logic                  is_read;
    logic [MON_ADDR_W-1:0] addr;
    logic [MON_DATA_W-1:0] data;
    logic [MON_BE_W-1:0]   be;
  } mon_entry_t;

  // Expand per-byte enables into a per-bit mask.
  function automatic logic [MON_DATA_W-1:0] be_to_mask(input logic [MON_BE_W-1:0] be);
    logic [MON_DATA_W-1:0] m;
    m = '0;
    for (int i = 0; i < int'(MON_BE_W); i++) begin
      m[i*8 +: 8] = {8{be[i]}};
    end
    return m;
  endfunction

endpackage

// File: rtl/sram_mon_fifo.sv
// Synchronous FIFO with valid/ready pop; pointers carry an extra wrap bit to tell full from empty.
module sram_mon_fifo
  import sram_mon_pkg::*;
#(
  parameter int unsigned DEPTH   = 16,
  parameter type         entry_t = mon_entry_t
) (
  input  logic   clk,
  input  logic   rst,
  input  logic   push_i,
  input  entry_t push_data_i,
  output logic   valid_o,
  input  logic   ready_i,
  output entry_t head_o,
  output logic   full_o,
  output logic   empty_o
);

  localparam int unsigned PTR_W = $clog2(DEPTH);

  entry_t           mem_q [DEPTH];
  logic [PTR_W:0]   wr_ptr_q, wr_ptr_d;
  logic [PTR_W:0]   rd_ptr_q, rd_ptr_d;
  logic             pop_c, push_ok_c;

  assign empty_o   = (wr_ptr_q == rd_ptr_q);
  assign full_o    = (wr_ptr_q[PTR_W] != rd_ptr_q[PTR_W]) &&
                     (wr_ptr_q[PTR_W-1:0] == rd_ptr_q[PTR_W-1:0]);
  assign valid_o   = !empty_o;
  assign head_o    = mem_q[rd_ptr_q[PTR_W-1:0]];
  assign pop_c     = valid_o && ready_i;
  // A full FIFO still accepts a push when the head is popped in the same cycle.
  assign push_ok_c = push_i && (!full_o || pop_c);

  always_comb begin
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    if (push_ok_c) wr_ptr_d = wr_ptr_q + (PTR_W+1)'(1);
    if (pop_c)     rd_ptr_d = rd_ptr_q + (PTR_W+1)'(1);
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
    end
  end

  always_ff @(posedge clk) begin
    if (push_ok_c) mem_q[wr_ptr_q[PTR_W-1:0]] <= push_data_i;
  end

endmodule

// File: rtl/sram_bus_monitor.sv
// Snoops NUM_CH async-SRAM buses, logs committed writes into a FIFO and checks one watch address.
// Optional read logging is enabled by defining MON_READ_LOG_EN.
module sram_bus_monitor
  import sram_mon_pkg::*;
#(
  parameter int unsigned             FIFO_DEPTH  = 16,
  parameter int unsigned             WATCH_CH    = 0,
  parameter logic [MON_ADDR_W-1:0]   WATCH_ADDR  = 20'hC0000,
  parameter logic [31:0]             TIMEOUT_CYC = 32'd1_000_000
) (
  input  logic                             clk_50M,
  input  logic                             reset_btn,
  input  logic [MON_NUM_CH*MON_ADDR_W-1:0] ram_addr,
  input  logic [MON_NUM_CH*MON_DATA_W-1:0] ram_data,
  input  logic [MON_NUM_CH-1:0]            ram_ce_n,
  input  logic [MON_NUM_CH-1:0]            ram_oe_n,
  input  logic [MON_NUM_CH-1:0]            ram_we_n,
  input  logic [MON_NUM_CH*MON_BE_W-1:0]   ram_be_n,
  input  logic                             chk_arm,
  input  logic [MON_DATA_W-1:0]            chk_expect,
  input  logic [MON_DATA_W-1:0]            chk_mask,
  output logic                             log_valid,
  input  logic                             log_ready,
  output mon_entry_t                       log_entry,
  output mon_status_e                      chk_status,
  output logic                             chk_done,
  output logic [MON_OVF_W-1:0]             ovf_count
);

  localparam int unsigned NUM_CH    = MON_NUM_CH;
  localparam int unsigned ADDR_W    = MON_ADDR_W;
  localparam int unsigned DATA_W    = MON_DATA_W;
  localparam int unsigned BE_W      = MON_BE_W;
  localparam int unsigned DROP_W    = $clog2(NUM_CH + 1);
  localparam int unsigned OVF_SUM_W = MON_OVF_W + 1;

  // Stage S1: one-cycle delayed copy of every bus
  logic [NUM_CH-1:0]        ce_n_s1_q, we_n_s1_q;
  logic [NUM_CH*ADDR_W-1:0] addr_s1_q;
  logic [NUM_CH*DATA_W-1:0] data_s1_q;
  logic [NUM_CH*BE_W-1:0]   be_n_s1_q;

  always_ff @(posedge clk_50M) begin
    if (reset_btn) begin
      ce_n_s1_q <= '1;
      we_n_s1_q <= '1;
      addr_s1_q <= '0;
      data_s1_q <= '0;
      be_n_s1_q <= '1;
    end else begin
      ce_n_s1_q <= ram_ce_n;
      we_n_s1_q <= ram_we_n;
      addr_s1_q <= ram_addr;
      data_s1_q <= ram_data;
      be_n_s1_q <= ram_be_n;
    end
  end

`ifdef MON_READ_LOG_EN
  logic [NUM_CH-1:0] oe_n_s1_q;
  always_ff @(posedge clk_50M) begin
    if (reset_btn) oe_n_s1_q <= '1;
    else           oe_n_s1_q <= ram_oe_n;
  end
`else
  logic unused_oe_c;
  assign unused_oe_c = ^ram_oe_n;
`endif

  logic [NUM_CH-1:0] wr_commit_c, commit_c;
  mon_entry_t        cm_entry_c [NUM_CH];

  for (genvar gi = 0; gi < NUM_CH; gi++) begin : g_ch
    logic [BE_W-1:0] be;
    logic            wr_end, rd_end;

    assign be     = ~be_n_s1_q[gi*BE_W +: BE_W];
    // Access ends when the strobe or chip enable deasserts after being active in S1
    assign wr_end = !ce_n_s1_q[gi] && !we_n_s1_q[gi] && (ram_we_n[gi] || ram_ce_n[gi]);
    assign wr_commit_c[gi] = wr_end && (be != '0);
`ifdef MON_READ_LOG_EN
    assign rd_end = !ce_n_s1_q[gi] && !oe_n_s1_q[gi] && we_n_s1_q[gi] &&
                    (ram_oe_n[gi] || ram_ce_n[gi]) && (be != '0);
`else
    assign rd_end = 1'b0;
`endif
    assign commit_c[gi]   = wr_commit_c[gi] || rd_end;
    assign cm_entry_c[gi] = '{ch:      MON_CH_W'(gi),
                              is_read: !wr_commit_c[gi],
                              addr:    addr_s1_q[gi*ADDR_W +: ADDR_W],
                              data:    data_s1_q[gi*DATA_W +: DATA_W],
                              be:      be};
  end

  mon_entry_t          hold_q [NUM_CH];
  mon_entry_t          hold_d [NUM_CH];
  logic [NUM_CH-1:0]   hold_v_q, hold_v_d;
  logic [NUM_CH-1:0]   grant_c;
  logic                push_c, can_push_c, fifo_full;
  mon_entry_t          push_data_c;
  logic [DROP_W-1:0]   drop_cnt_c;

  assign can_push_c = !fifo_full || (log_valid && log_ready);

  // Fixed-priority arbiter: lowest occupied channel wins the FIFO slot
  always_comb begin
    grant_c     = '0;
    push_c      = 1'b0;
    push_data_c = '0;
    for (int i = 0; i < int'(NUM_CH); i++) begin
      if (can_push_c && hold_v_q[i] && !push_c) begin
        grant_c[i]  = 1'b1;
        push_c      = 1'b1;
        push_data_c = hold_q[i];
      end
    end
  end

  always_comb begin
    hold_v_d   = hold_v_q;
    hold_d     = hold_q;
    drop_cnt_c = '0;
    for (int i = 0; i < int'(NUM_CH); i++) begin
      if (grant_c[i]) hold_v_d[i] = 1'b0;
      if (commit_c[i]) begin
        if (hold_v_q[i]) begin
          drop_cnt_c = drop_cnt_c + DROP_W'(1);
        end else begin
          hold_v_d[i] = 1'b1;
          hold_d[i]   = cm_entry_c[i];
        end
      end
    end
  end

  always_ff @(posedge clk_50M) begin
    if (reset_btn) begin
      hold_v_q <= '0;
      hold_q   <= '{default: '0};
    end else begin
      hold_v_q <= hold_v_d;
      hold_q   <= hold_d;
    end
  end

  sram_mon_fifo #(
    .DEPTH   (FIFO_DEPTH),
    .entry_t (mon_entry_t)
  ) u_fifo (
    .clk         (clk_50M),
    .rst         (reset_btn),
    .push_i      (push_c),
    .push_data_i (push_data_c),
    .valid_o     (log_valid),
    .ready_i     (log_ready),
    .head_o      (log_entry),
    .full_o      (fifo_full),
    .empty_o     ()
  );

  logic [MON_OVF_W-1:0] ovf_q, ovf_d;
  logic [OVF_SUM_W-1:0] ovf_sum_c;

  assign ovf_sum_c = {1'b0, ovf_q} + OVF_SUM_W'(drop_cnt_c);
  assign ovf_d     = ovf_sum_c[MON_OVF_W] ? '1 : ovf_sum_c[MON_OVF_W-1:0];

  always_ff @(posedge clk_50M) begin
    if (reset_btn) ovf_q <= '0;
    else           ovf_q <= ovf_d;
  end

  assign ovf_count = ovf_q;

  logic watch_hit_c, watch_ok_c;

  assign watch_hit_c = wr_commit_c[WATCH_CH +: 1] &&
                       (addr_s1_q[WATCH_CH*ADDR_W +: ADDR_W] == WATCH_ADDR);
  assign watch_ok_c  = ((data_s1_q[WATCH_CH*DATA_W +: DATA_W] ^ chk_expect) & chk_mask &
                        be_to_mask(~be_n_s1_q[WATCH_CH*BE_W +: BE_W])) == '0;

  mon_status_e status_q, status_d;
  logic [31:0] tmo_cnt_q, tmo_cnt_d;
  logic        done_q, done_d;

  always_ff @(posedge clk_50M) begin
    if (reset_btn) begin
      status_q  <= ARMED;
      tmo_cnt_q <= '0;
      done_q    <= 1'b0;
    end else begin
      status_q  <= status_d;
      tmo_cnt_q <= tmo_cnt_d;
      done_q    <= done_d;
    end
  end

  // Arm overrides everything; a watch write beats a timeout in the same cycle
  always_comb begin
    status_d  = status_q;
    tmo_cnt_d = tmo_cnt_q;
    if (chk_arm) begin
      status_d  = ARMED;
      tmo_cnt_d = '0;
    end else begin
      case (status_q)
        ARMED: begin
          if (watch_hit_c)                          status_d = watch_ok_c ? PASS : FAIL;
          else if (tmo_cnt_q == TIMEOUT_CYC - 32'd1) status_d = TIMEOUT;
          else                                      tmo_cnt_d = tmo_cnt_q + 32'd1;
        end
        default: ;
      endcase
    end
    done_d = (status_d != ARMED);
  end

  assign chk_status = status_q;
  assign chk_done   = done_q;

endmodule
